// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary neuron sequencer.
package bnn_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, WAIT, OUTPUT} state_t;

  localparam int THRESH_W = 32;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bnn_weight_ram.sv
// Simple dual-port weight store: one write port, one registered read port.
module bnn_weight_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bnn_neuron_sequencer.sv
// Buffers one input vector, streams (x, w) pairs per neuron to a shared
// XNOR/popcount processor and packs the per-neuron result bits.
module bnn_neuron_sequencer
  import bnn_pkg::*;
#(
  parameter int PARALLEL_INPUTS = 8,
  parameter int INPUT_WORDS     = 16,
  parameter int NUM_NEURONS     = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               w_we,
  input  logic [clog2_min1(NUM_NEURONS*INPUT_WORDS)-1:0]     w_addr,
  input  logic [PARALLEL_INPUTS-1:0]                         w_wdata,
  input  logic                                               thr_we,
  input  logic [clog2_min1(NUM_NEURONS)-1:0]                 thr_addr,
  input  logic [THRESH_W-1:0]                                thr_wdata,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [PARALLEL_INPUTS-1:0]                         in_data,
  output logic [PARALLEL_INPUTS-1:0]                         np_x,
  output logic [PARALLEL_INPUTS-1:0]                         np_w,
  output logic [THRESH_W-1:0]                                np_threshold,
  output logic                                               np_valid,
  output logic                                               np_eof,
  output logic                                               np_clear,
  input  logic                                               np_valid_out,
  input  logic                                               np_out,
  output logic                                               res_valid,
  input  logic                                               res_ready,
  output logic [NUM_NEURONS-1:0]                             res_data
);

  localparam int DEPTH = NUM_NEURONS * INPUT_WORDS;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int NW    = clog2_min1(NUM_NEURONS);
  localparam int WCW   = clog2_min1(INPUT_WORDS);

  state_t                     state;
  logic [WCW-1:0]             word_cnt;
  logic [NW-1:0]              neuron_cnt;
  logic [PARALLEL_INPUTS-1:0] in_buf  [INPUT_WORDS];
  logic [THRESH_W-1:0]        thr_mem [NUM_NEURONS];

  logic          cfg_open, in_fire, emit, last_word, last_neuron, w_wr;
  logic [AW-1:0] rd_addr;

  assign cfg_open    = (state == IDLE) || (state == LOAD);
  assign in_fire     = in_valid && in_ready;
  // A word goes out on every edge leaving CLEAR and every STREAM edge until eof has been sent.
  assign emit        = (state == CLEAR) || ((state == STREAM) && !np_eof);
  assign last_word   = (word_cnt == WCW'(INPUT_WORDS - 1));
  assign last_neuron = (neuron_cnt == NW'(NUM_NEURONS - 1));
  assign w_wr        = w_we && cfg_open && (int'(w_addr) < DEPTH);
  assign rd_addr     = AW'(int'(neuron_cnt) * INPUT_WORDS + int'(word_cnt));

  always_ff @(posedge clk) begin
    if (in_fire) in_buf[word_cnt] <= in_data;
    if (thr_we && cfg_open && (int'(thr_addr) < NUM_NEURONS)) thr_mem[thr_addr] <= thr_wdata;
  end

  bnn_weight_ram #(
    .DW   (PARALLEL_INPUTS),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_wram (
    .clk  (clk),
    .rst  (rst),
    .we   (w_wr),
    .waddr(w_addr),
    .wdata(w_wdata),
    .re   (emit),
    .raddr(rd_addr),
    .rdata(np_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      neuron_cnt   <= '0;
      in_ready     <= 1'b0;
      np_x         <= '0;
      np_threshold <= '0;
      np_valid     <= 1'b0;
      np_eof       <= 1'b0;
      np_clear     <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      np_clear <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            if (last_word) begin
              state        <= CLEAR;
              word_cnt     <= '0;
              in_ready     <= 1'b0;
              np_clear     <= 1'b1;
              np_threshold <= thr_mem[neuron_cnt];
            end else begin
              state    <= LOAD;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        CLEAR, STREAM: begin
          if (emit) begin
            state    <= STREAM;
            np_x     <= in_buf[word_cnt];
            np_valid <= 1'b1;
            np_eof   <= last_word;
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
          end else begin
            state    <= WAIT;
            np_valid <= 1'b0;
            np_eof   <= 1'b0;
          end
        end
        WAIT: begin
          if (np_valid_out) begin
            res_data[neuron_cnt] <= np_out;
            if (last_neuron) begin
              state     <= OUTPUT;
              res_valid <= 1'b1;
            end else begin
              state        <= CLEAR;
              neuron_cnt   <= neuron_cnt + 1'b1;
              np_clear     <= 1'b1;
              np_threshold <= thr_mem[neuron_cnt + 1'b1];
            end
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            state      <= IDLE;
            res_valid  <= 1'b0;
            res_data   <= '0;
            neuron_cnt <= '0;
            word_cnt   <= '0;
            in_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_neuron_sequencer.sv
// Randomized self-checking bench with a behavioural XNOR/popcount processor.
module tb_bnn_neuron_sequencer;
  localparam int P = 8, W = 4, N = 3, AW = 4, NW = 2;
  localparam int LAT = N * (W + 4);

  logic          clk = 1'b0, rst = 1'b1;
  logic          w_we = 0, thr_we = 0, in_valid = 0, res_ready = 0;
  logic [AW-1:0] w_addr = '0;
  logic [P-1:0]  w_wdata = '0, in_data = '0;
  logic [NW-1:0] thr_addr = '0;
  logic [31:0]   thr_wdata = '0;
  logic          in_ready, np_valid, np_eof, np_clear, res_valid;
  logic [P-1:0]  np_x, np_w;
  logic [31:0]   np_threshold;
  logic          np_valid_out, np_out;
  logic [N-1:0]  res_data;

  bnn_neuron_sequencer #(.PARALLEL_INPUTS(P), .INPUT_WORDS(W), .NUM_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_wdata(thr_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .np_x(np_x), .np_w(np_w), .np_threshold(np_threshold), .np_valid(np_valid),
    .np_eof(np_eof), .np_clear(np_clear), .np_valid_out(np_valid_out), .np_out(np_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor stand-in: accumulate XNOR popcount, result 3 edges after the eof word.
  int   acc;
  logic s1_v, s1_b, s2_v, s2_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 0; s1_v <= 0; s1_b <= 0; s2_v <= 0; s2_b <= 0;
      np_valid_out <= 0; np_out <= 0;
    end else begin
      if (np_clear) acc <= 0;
      else if (np_valid) acc <= acc + $countones(~(np_x ^ np_w));
      s1_v <= np_valid && np_eof;
      s1_b <= (32'(acc + $countones(~(np_x ^ np_w))) >= np_threshold);
      s2_v <= s1_v; s2_b <= s1_b;
      np_valid_out <= s2_v; np_out <= s2_b;
    end
  end

  int clr_total = 0, vld_total = 0, eof_bad = 0, vidx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (np_clear) begin
        clr_total <= clr_total + 1; vidx <= 0;
      end else if (np_valid) begin
        vld_total <= vld_total + 1;
        if (np_eof !== (vidx == W - 1)) eof_bad <= eof_bad + 1;
        vidx <= vidx + 1;
      end else if (np_eof) eof_bad <= eof_bad + 1;
    end
  end

  logic [7:0]  xref [W];
  logic [7:0]  wref [N][W];
  logic [31:0] tref [N];
  int n_checks = 0, n_pass = 0, hs_cyc = 0;

  function automatic logic [N-1:0] model_res();
    logic [N-1:0] r;
    for (int n = 0; n < N; n++) begin
      int pop = 0;
      for (int k = 0; k < W; k++) pop += $countones(~(xref[k] ^ wref[n][k]));
      r[n] = (32'(pop) >= tref[n]);
    end
    return r;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic write_cfg(input bit dw, input int wa, input logic [7:0] wd,
                           input bit dt, input int ta, input logic [31:0] td);
    w_we = dw; w_addr = AW'(wa); w_wdata = wd;
    thr_we = dt; thr_addr = NW'(ta); thr_wdata = td;
    tick();
    w_we = 0; thr_we = 0;
  endtask

  task automatic program_model();
    for (int n = 0; n < N; n++)
      for (int k = 0; k < W; k++) write_cfg(1, n * W + k, wref[n][k], k == 0, n, tref[n]);
  endtask

  task automatic rand_cfg();
    for (int n = 0; n < N; n++) begin
      tref[n] = 32'($urandom_range(10, 22));
      for (int k = 0; k < W; k++) wref[n][k] = 8'($urandom);
    end
    for (int k = 0; k < W; k++) xref[k] = 8'($urandom);
  endtask

  task automatic send_word(input logic [7:0] d, output bit ok);
    in_valid = 1; in_data = d; ok = 0;
    for (int b = 0; b < 50; b++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (ok) tick();
    hs_cyc = cyc; in_valid = 0;
  endtask

  task automatic send_vector(output bit ok);
    bit o;
    ok = 1;
    for (int k = 0; k < W; k++) begin send_word(xref[k], o); ok &= o; end
  endtask

  task automatic wait_result(output bit ok, output int lat);
    ok = 0;
    for (int b = 0; b < 400; b++) begin
      if (res_valid) begin ok = 1; break; end
      tick();
    end
    lat = cyc - hs_cyc;
  endtask

  task automatic take_result(); res_ready = 1; tick(); res_ready = 0; endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    n_checks++;
    if ({in_ready, np_valid, np_eof, np_clear, res_valid, res_data, np_x, np_w, np_threshold} !== '0)
      $display("FAIL reset_outputs: in_ready=%b np_valid=%b res_valid=%b res_data=%b np_x=%h np_w=%h thr=%0d, want all 0",
               in_ready, np_valid, res_valid, res_data, np_x, np_w, np_threshold);
    else n_pass++;
    rst = 0; tick(); tick();
    n_checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL idle_ready: in_ready=%b res_valid=%b, want 1/0", in_ready, res_valid);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    bit ok; int lat;
    for (int n = 0; n < N; n++) for (int k = 0; k < W; k++) wref[n][k] = 8'hFF;
    tref[0] = 32; tref[1] = 16; tref[2] = 33;
    for (int k = 0; k < W; k++) xref[k] = 8'hFF;
    program_model();
    send_vector(ok);
    wait_result(ok, lat);
    n_checks++;
    if (!ok) $display("FAIL ones_timeout: res_valid=%b, want 1", res_valid); else n_pass++;
    n_checks++;
    if (res_data !== 3'b011) $display("FAIL ones_result: got %b want 011", res_data); else n_pass++;
    n_checks++;
    if (lat !== LAT) $display("FAIL ones_latency: got %0d want %0d", lat, LAT); else n_pass++;
    take_result();
  endtask

  task automatic test_pattern_backpressure();
    bit ok, stable; int lat, c0, v0, e0;
    logic [N-1:0] held;
    xref[0] = 8'hA5; xref[1] = 8'h5A; xref[2] = 8'h00; xref[3] = 8'hFF;
    for (int n = 0; n < N; n++) begin
      tref[n] = 17;
      for (int k = 0; k < W; k++) wref[n][k] = (n == 1) ? xref[k] : ~xref[k];
    end
    program_model();
    c0 = clr_total; v0 = vld_total; e0 = eof_bad;
    send_vector(ok);
    wait_result(ok, lat);
    n_checks++;
    if (!ok || res_data !== model_res() || res_data !== 3'b010)
      $display("FAIL pattern_result: got %b want %b (valid=%b)", res_data, model_res(), ok);
    else n_pass++;
    n_checks++;
    if (clr_total - c0 !== 3) $display("FAIL pattern_clears: got %0d want 3", clr_total - c0); else n_pass++;
    n_checks++;
    if (vld_total - v0 !== N * W || eof_bad - e0 !== 0)
      $display("FAIL pattern_stream: valid_cycles=%0d eof_errors=%0d want %0d/0", vld_total - v0, eof_bad - e0, N * W);
    else n_pass++;
    held = res_data; stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== held || in_ready !== 1'b0) stable = 0;
    end
    n_checks++;
    if (!stable) $display("FAIL hold_stable: res_valid=%b res_data=%b in_ready=%b want 1/%b/0", res_valid, res_data, in_ready, held);
    else n_pass++;
    take_result();
    n_checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_take: res_valid=%b in_ready=%b want 0/1", res_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_cfg_ignored();
    bit ok, seen; int lat;
    tref[0] = 8;
    write_cfg(0, 0, 8'h00, 1, 0, tref[0]);
    send_vector(ok);
    seen = 0;
    for (int b = 0; b < 20; b++) begin
      if (np_valid) begin seen = 1; break; end
      tick();
    end
    write_cfg(1, 0, xref[0], 1, 2, 32'd0);
    n_checks++;
    if (!seen) $display("FAIL ignore_stream_reached: np_valid=%b want 1", np_valid); else n_pass++;
    wait_result(ok, lat);
    n_checks++;
    if (!ok || res_data !== model_res())
      $display("FAIL ignore_write: got %b want %b (valid=%b)", res_data, model_res(), ok);
    else n_pass++;
    take_result();
    wref[0][0] = xref[0];
    write_cfg(1, 0, wref[0][0], 0, 0, 32'd0);
    send_vector(ok);
    wait_result(ok, lat);
    n_checks++;
    if (!ok || res_data !== model_res() || res_data !== 3'b011)
      $display("FAIL idle_write: got %b want %b (valid=%b)", res_data, model_res(), ok);
    else n_pass++;
    take_result();
  endtask

  task automatic test_load_stall();
    bit ok, o, quiet; int lat;
    rand_cfg();
    program_model();
    ok = 1;
    send_word(xref[0], o); ok &= o;
    send_word(xref[1], o); ok &= o;
    quiet = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (in_ready !== 1'b1 || np_valid !== 1'b0 || np_clear !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet) $display("FAIL stall_hold: in_ready=%b np_valid=%b np_clear=%b want 1/0/0", in_ready, np_valid, np_clear);
    else n_pass++;
    send_word(xref[2], o); ok &= o;
    send_word(xref[3], o); ok &= o;
    wait_result(o, lat);
    n_checks++;
    if (!ok || !o || res_data !== model_res() || lat !== LAT)
      $display("FAIL stall_result: got %b lat %0d want %b lat %0d", res_data, lat, model_res(), LAT);
    else n_pass++;
    take_result();
  endtask

  task automatic test_reset_mid();
    bit ok, o, hit, stale; int lat, clears;
    rand_cfg();
    program_model();
    send_vector(ok);
    clears = 0; hit = 0;
    for (int b = 0; b < 60; b++) begin
      if (np_clear) clears++;
      if (clears == 2 && np_valid) begin hit = 1; break; end
      tick();
    end
    rst = 1; #1;
    n_checks++;
    if (!hit || {in_ready, np_valid, np_eof, np_clear, res_valid, res_data, np_x, np_w, np_threshold} !== '0)
      $display("FAIL midreset_outputs: reached=%b np_valid=%b np_x=%h np_w=%h res_valid=%b, want all 0",
               hit, np_valid, np_x, np_w, res_valid);
    else n_pass++;
    @(posedge clk); #1; rst = 0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (res_valid || np_valid) stale = 1; end
    n_checks++;
    if (stale) $display("FAIL midreset_stale: res_valid/np_valid seen=1 want 0"); else n_pass++;
    rand_cfg();
    program_model();
    send_vector(ok);
    wait_result(o, lat);
    n_checks++;
    if (!ok || !o || res_data !== model_res() || lat !== LAT)
      $display("FAIL midreset_result: got %b lat %0d want %b lat %0d", res_data, lat, model_res(), LAT);
    else n_pass++;
    take_result();
  endtask

  task automatic test_back_to_back();
    bit ok, o; int lat;
    for (int it = 0; it < 5; it++) begin
      rand_cfg();
      program_model();
      send_vector(ok);
      wait_result(o, lat);
      n_checks++;
      if (!ok || !o || res_data !== model_res() || lat !== LAT)
        $display("FAIL b2b_%0d: got %b lat %0d want %b lat %0d", it, res_data, lat, model_res(), LAT);
      else n_pass++;
      repeat ($urandom_range(0, 3)) tick();
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern_backpressure();
    test_cfg_ignored();
    test_load_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
